// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// load/store funct3 encodings, controller states and an opcode helper.
package dcache_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [31:0] BAD_LOAD_WORD = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // True for the five funct3 codes that describe a real load.
  function automatic logic isLoadOp(input logic [2:0] funct3);
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte/half/word alignment for one cache line word: extracts and extends
// load results and merges store data into the line.
module load_store_align
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_lineWord,
  input  logic [DATA_WIDTH-1:0] i_storeData,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_loadData,
  output logic                  o_loadOk,
  output logic [DATA_WIDTH-1:0] o_mergedWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte/half and extend it as the load code asks.
  always_comb begin
    w_byte   = i_lineWord[{i_offset, 3'b000} +: 8];
    w_half   = i_lineWord[{i_offset[1], 4'b0000} +: 16];
    o_loadOk = isLoadOp(i_funct3);
    case (i_funct3)
      LB:      o_loadData = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LH:      o_loadData = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      LW:      o_loadData = i_lineWord;
      LBU:     o_loadData = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LHU:     o_loadData = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_loadData = DATA_WIDTH'(BAD_LOAD_WORD);
    endcase
  end

  // Overlay the store data onto the line word; halves land at a&~1.
  always_comb begin
    o_mergedWord = i_lineWord;
    case (i_funct3)
      SB:      o_mergedWord[{i_offset, 3'b000} +: 8]     = i_storeData[7:0];
      SH:      o_mergedWord[{i_offset[1], 4'b0000} +: 16] = i_storeData[15:0];
      SW:      o_mergedWord = i_storeData;
      default: o_mergedWord = i_lineWord;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data
// cache. Load misses take one extra FILL cycle, then replay as a hit.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_WIDTH-1:0]    writedata,
  input  logic [2:0]               memcontrol,
  output logic [DATA_WIDTH-1:0]    readdata,
  output logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_writedata,
  output logic [2:0]               mem_memcontrol,
  input  logic [DATA_WIDTH-1:0]    mem_readdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;
  localparam int LINE_W = ADDRESS_WIDTH - 2;

  state_t r_state;
  state_t w_next;

  logic [SETS-1:0]       r_valid;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS];
  logic [LINE_W-1:0]     r_fillLine;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_loadData;
  logic                  w_loadOk;
  logic [DATA_WIDTH-1:0] w_merged;

  logic                  w_lineWrite;
  logic [IDX_W-1:0]      w_lineIdx;
  logic [TAG_W-1:0]      w_lineTag;
  logic [DATA_WIDTH-1:0] w_lineData;

  assign w_idx = a[2 +: IDX_W];
  assign w_tag = a[ADDRESS_WIDTH-1 -: TAG_W];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  load_store_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_lineWord  (r_data[w_idx]),
    .i_storeData (writedata),
    .i_offset    (a[1:0]),
    .i_funct3    (memcontrol),
    .o_loadData  (w_loadData),
    .o_loadOk    (w_loadOk),
    .o_mergedWord(w_merged)
  );

  // Next state, cache outputs, downstream port and line-write request.
  always_comb begin
    w_next         = r_state;
    stall          = 1'b0;
    readdata       = '0;
    mem_a          = a;
    mem_we         = 1'b0;
    mem_writedata  = writedata;
    mem_memcontrol = memcontrol;
    w_lineWrite    = 1'b0;
    w_lineIdx      = w_idx;
    w_lineTag      = w_tag;
    w_lineData     = w_merged;
    if (rst) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (we) begin
            mem_we      = 1'b1;
            w_lineWrite = w_hit;
          end else if (re) begin
            if (!w_loadOk) begin
              readdata = w_loadData;
            end else if (w_hit) begin
              readdata = w_loadData;
            end else begin
              stall  = 1'b1;
              w_next = FILL;
            end
          end
        end
        FILL: begin
          stall          = 1'b1;
          mem_a          = {r_fillLine, 2'b00};
          mem_memcontrol = LW;
          w_lineWrite    = 1'b1;
          w_lineIdx      = r_fillLine[IDX_W-1:0];
          w_lineTag      = r_fillLine[LINE_W-1 -: TAG_W];
          w_lineData     = mem_readdata;
          w_next         = IDLE;
        end
      endcase
    end
  end

  // Controller state and valid bits; only these are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
    end else begin
      r_state <= w_next;
      if (w_lineWrite) r_valid[w_lineIdx] <= 1'b1;
    end
  end

  // Line tag/data storage and the captured miss address, never reset.
  always_ff @(posedge clk) begin
    if (w_lineWrite) begin
      r_tag[w_lineIdx]  <= w_lineTag;
      r_data[w_lineIdx] <= w_lineData;
    end
    if (r_state == IDLE && w_next == FILL) r_fillLine <= a[ADDRESS_WIDTH-1:2];
  end

`ifdef DCACHE_STATS_EN
  logic        r_replay;
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;
  logic        w_countHit;
  logic        w_countMiss;

  assign w_countMiss = (r_state == IDLE) && (w_next == FILL);
  assign w_countHit  = !rst && (r_state == IDLE) && !we && re && w_loadOk &&
                       w_hit && !r_replay;
  assign hit_count   = r_hitCount;
  assign miss_count  = r_missCount;

  // Hit/miss counters; the post-fill replay hit is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_replay    <= 1'b0;
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      r_replay <= (r_state == FILL);
      if (w_countHit)  r_hitCount  <= r_hitCount + 32'd1;
      if (w_countMiss) r_missCount <= r_missCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized
// loads/stores compared against a set/tag + flat-memory reference model.
module tb_dcache;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic        we, re;
  logic [31:0] writedata;
  logic [2:0]  memcontrol;
  logic [31:0] readdata;
  logic        stall;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_writedata;
  logic [2:0]  mem_memcontrol;
  logic [31:0] mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] envMem  [256];
  logic [31:0] goldMem [256];
  logic        refValid [8];
  logic [31:0] refTag   [8];
  int          refHits, refMisses;

  dcache dut (
    .clk(clk), .rst(rst), .a(a), .we(we), .re(re), .writedata(writedata),
    .memcontrol(memcontrol), .readdata(readdata), .stall(stall),
    .mem_a(mem_a), .mem_we(mem_we), .mem_writedata(mem_writedata),
    .mem_memcontrol(mem_memcontrol), .mem_readdata(mem_readdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference memory semantics: store byte/half/word into a word.
  function automatic logic [31:0] refStore(logic [31:0] w, logic [1:0] off,
                                           logic [2:0] f3, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    case (f3)
      3'b000: begin sh = 8 * off; mask = 32'hFF << sh;
                    return (w & ~mask) | ((d & 32'hFF) << sh); end
      3'b001: begin sh = off[1] ? 16 : 0; mask = 32'hFFFF << sh;
                    return (w & ~mask) | ((d & 32'hFFFF) << sh); end
      3'b010: return d;
      default: return w;
    endcase
  endfunction

  // Reference load result from a word using plain arithmetic.
  function automatic logic [31:0] refLoad(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'b000: return (b >= 128) ? b - 32'd256 : b;
      3'b001: return (h >= 32768) ? h - 32'd65536 : h;
      3'b010: return w;
      3'b100: return b;
      3'b101: return h;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Predict stall cycles of a valid load and update the cache model.
  function automatic int refLoadStalls(logic [31:0] addr);
    int set;
    set = (addr / 4) % 8;
    if (refValid[set] && refTag[set] == addr / 32) begin
      refHits++;
      return 0;
    end
    refValid[set] = 1'b1;
    refTag[set]   = addr / 32;
    refMisses++;
    return 2;
  endfunction

  // Downstream memory: combinational read, synchronous merged write.
  assign mem_readdata = envMem[mem_a[9:2]];
  always @(posedge clk)
    if (mem_we) envMem[mem_a[9:2]] = refStore(envMem[mem_a[9:2]], mem_a[1:0], mem_memcontrol, mem_writedata);

  task automatic doReset();
    rst = 1'b1; re = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
    refHits = 0; refMisses = 0;
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [2:0] f3,
                        output logic [31:0] data, output int stalls);
    logic got;
    a = addr; memcontrol = f3; re = 1'b1; we = 1'b0;
    stalls = 0; got = 1'b0; data = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!stall) begin data = readdata; got = 1'b1; break; end
      stalls++;
      @(posedge clk); #1;
    end
    if (!got) stalls = 99;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] d,
                         input logic alsoRe, output logic sStall, output logic sWe);
    a = addr; memcontrol = f3; writedata = d; we = 1'b1; re = alsoRe;
    @(negedge clk);
    sStall = stall; sWe = mem_we;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; int st;
    doReset();
    doLoad(32'h10080, LW, d, st);
    rst = 1'b1; re = 1'b1; we = 1'b1; a = 32'h10080; memcontrol = LW;
    @(negedge clk);
    tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL rst_stall: got %b want 0", stall); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL rst_mem_we: got %b want 0", mem_we); end
    tests++; if (readdata !== 32'h0) begin fails++; $display("[TB] FAIL rst_readdata: got %h want 0", readdata); end
    @(posedge clk); #1;
    doReset();
    doLoad(32'h10080, LW, d, st);
    tests++; if (st !== refLoadStalls(32'h10080)) begin fails++; $display("[TB] FAIL rst_invalidates: got %0d stall cycles want 2", st); end
  endtask

  task automatic test_miss_then_hit();
    logic [31:0] d; int st, exp;
    doReset();
    envMem[0] = 32'h12345678; goldMem[0] = 32'h12345678;
    exp = refLoadStalls(32'h10000);
    doLoad(32'h10000, LW, d, st);
    tests++; if (st !== exp) begin fails++; $display("[TB] FAIL miss_latency: got %0d want %0d", st, exp); end
    tests++; if (d !== goldMem[0]) begin fails++; $display("[TB] FAIL miss_data: got %h want %h", d, goldMem[0]); end
    exp = refLoadStalls(32'h10000);
    doLoad(32'h10000, LW, d, st);
    tests++; if (st !== exp) begin fails++; $display("[TB] FAIL hit_latency: got %0d want %0d", st, exp); end
    tests++; if (d !== goldMem[0]) begin fails++; $display("[TB] FAIL hit_data: got %h want %h", d, goldMem[0]); end
  endtask

  task automatic test_extract();
    logic [31:0] d; logic s, w; int st;
    logic [2:0]  f3s [4];
    logic [31:0] ads [4];
    f3s = '{LB, LBU, LH, LHU};
    ads = '{32'h10002, 32'h10002, 32'h10002, 32'h10000};
    doStore(32'h10000, SW, 32'h80FF7F01, 1'b0, s, w);
    goldMem[0] = refStore(goldMem[0], 2'd0, SW, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      doLoad(ads[i], f3s[i], d, st);
      tests++; if (d !== refLoad(goldMem[0], ads[i][1:0], f3s[i]) || st !== 0) begin
        fails++; $display("[TB] FAIL extract_%0d: got %h/%0d want %h/0", i, d, st, refLoad(goldMem[0], ads[i][1:0], f3s[i]));
      end
    end
  endtask

  task automatic test_store_hit();
    logic [31:0] d; logic s, w; int st;
    doStore(32'h10001, SB, 32'h000000AB, 1'b0, s, w);
    goldMem[0] = refStore(goldMem[0], 2'd1, SB, 32'hAB);
    tests++; if (s !== 1'b0 || w !== 1'b1) begin fails++; $display("[TB] FAIL sb_cycle: got stall=%b we=%b want 0/1", s, w); end
    tests++; if (envMem[0] !== goldMem[0]) begin fails++; $display("[TB] FAIL sb_memory: got %h want %h", envMem[0], goldMem[0]); end
    doLoad(32'h10000, LW, d, st);
    tests++; if (d !== goldMem[0] || st !== refLoadStalls(32'h10000)) begin fails++; $display("[TB] FAIL sb_merge: got %h/%0d want %h/0", d, st, goldMem[0]); end
  endtask

  task automatic test_store_miss();
    logic [31:0] d; logic s, w; int st, exp;
    doStore(32'h10100, SW, 32'hCAFEF00D, 1'b0, s, w);
    goldMem[64] = 32'hCAFEF00D;
    tests++; if (s !== 1'b0 || w !== 1'b1) begin fails++; $display("[TB] FAIL sw_cycle: got stall=%b we=%b want 0/1", s, w); end
    @(negedge clk);
    tests++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL sw_we_one_cycle: got %b want 0", mem_we); end
    @(posedge clk); #1;
    exp = refLoadStalls(32'h10100);
    doLoad(32'h10100, LW, d, st);
    tests++; if (st !== exp || d !== goldMem[64]) begin fails++; $display("[TB] FAIL sw_no_allocate: got %h/%0d want %h/%0d", d, st, goldMem[64], exp); end
  endtask

  task automatic test_evict();
    logic [31:0] d; int st, exp;
    logic [31:0] ads [3];
    ads = '{32'h10000, 32'h10020, 32'h10000};
    doReset();
    for (int i = 0; i < 3; i++) begin
      exp = refLoadStalls(ads[i]);
      doLoad(ads[i], LW, d, st);
      tests++; if (st !== exp || d !== goldMem[ads[i][9:2]]) begin
        fails++; $display("[TB] FAIL evict_%0d: got %h/%0d want %h/%0d", i, d, st, goldMem[ads[i][9:2]], exp);
      end
    end
`ifdef DCACHE_STATS_EN
    tests++; if (miss_count !== refMisses || hit_count !== refHits) begin
      fails++; $display("[TB] FAIL evict_stats: got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, refHits, refMisses);
    end
`endif
  endtask

  task automatic test_reset_during_fill();
    logic [31:0] d; int st, exp;
    a = 32'h10040; memcontrol = LW; re = 1'b1; we = 1'b0;
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin fails++; $display("[TB] FAIL rfill_miss_stall: got %b want 1", stall); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL rfill_rst_stall: got %b want 0", stall); end
    @(posedge clk); #1 rst = 1'b0; re = 1'b0;
    for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
    refHits = 0; refMisses = 0;
    @(negedge clk);
    tests++; if (stall !== 1'b0 || readdata !== 32'h0) begin fails++; $display("[TB] FAIL rfill_idle: got stall=%b rd=%h want 0/0", stall, readdata); end
    @(posedge clk); #1;
    exp = refLoadStalls(32'h10040);
    doLoad(32'h10040, LW, d, st);
    tests++; if (st !== exp || d !== goldMem[16]) begin fails++; $display("[TB] FAIL rfill_remiss: got %h/%0d want %h/%0d", d, st, goldMem[16], exp); end
  endtask

  task automatic test_random();
    logic [31:0] d, addr, expData; logic s, w; int st, expSt, wi, r;
    logic [1:0]  off; logic [2:0] f3;
    logic [2:0]  loadOps [7];
    logic [2:0]  storeOps [3];
    loadOps  = '{LB, LH, LW, LBU, LHU, 3'b011, 3'b111};
    storeOps = '{SB, SH, SW};
    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      wi = $urandom_range(0, 63);
      if (r < 8) begin
        f3 = (r < 5) ? loadOps[$urandom_range(0, 6)] : storeOps[$urandom_range(0, 2)];
        case (f3[1:0])
          2'b00:   off = 2'($urandom_range(0, 3));
          2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
          default: off = 2'b00;
        endcase
        addr = 32'h10000 + wi * 4 + {30'd0, off};
      end else begin
        f3 = 3'b000; off = 2'b00; addr = 32'h10000;
      end
      if (r < 5) begin
        if (isLoadOp(f3)) begin
          expSt = refLoadStalls(addr); expData = refLoad(goldMem[wi], off, f3);
        end else begin
          expSt = 0; expData = 32'hDEADBEEF;
        end
        doLoad(addr, f3, d, st);
        tests++; if (st !== expSt || d !== expData) begin
          fails++; $display("[TB] FAIL rand_load a=%h f3=%b: got %h/%0d want %h/%0d", addr, f3, d, st, expData, expSt);
        end
      end else if (r < 8) begin
        d = $urandom;
        doStore(addr, f3, d, 1'($urandom_range(0, 1)), s, w);
        goldMem[wi] = refStore(goldMem[wi], off, f3, d);
        tests++; if (s !== 1'b0 || w !== 1'b1 || envMem[wi] !== goldMem[wi]) begin
          fails++; $display("[TB] FAIL rand_store a=%h f3=%b: got stall=%b we=%b mem=%h want 0/1/%h", addr, f3, s, w, envMem[wi], goldMem[wi]);
        end
      end else begin
        a = $urandom; re = 1'b0; we = 1'b0;
        @(negedge clk);
        tests++; if (readdata !== 32'h0 || stall !== 1'b0 || mem_we !== 1'b0) begin
          fails++; $display("[TB] FAIL rand_idle: got rd=%h stall=%b we=%b want 0/0/0", readdata, stall, mem_we);
        end
        @(posedge clk); #1;
      end
    end
`ifdef DCACHE_STATS_EN
    tests++; if (hit_count !== refHits || miss_count !== refMisses) begin
      fails++; $display("[TB] FAIL rand_stats: got hit=%0d miss=%0d want %0d/%0d", hit_count, miss_count, refHits, refMisses);
    end
`endif
  endtask

  // Abort guard so the run always ends even if the DUT wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; a = '0; we = 1'b0; re = 1'b0; writedata = '0; memcontrol = LW;
    for (int i = 0; i < 256; i++) begin
      envMem[i]  = $urandom;
      goldMem[i] = envMem[i];
    end
    test_reset();
    test_miss_then_hit();
    test_extract();
    test_store_hit();
    test_store_miss();
    test_evict();
    test_reset_during_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-003 SHALL have parameter SETS, default 8, meaning number of direct-mapped one-word lines; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port a, input, ADDRESS_WIDTH, the byte address from ALUResult.
REQ-007 SHALL have port we, input, 1, the store request.
REQ-008 SHALL have port re, input, 1, the load request.
REQ-009 SHALL have port writedata, input, DATA_WIDTH, the store data.
REQ-010 SHALL have port memcontrol, input, 3, the load/store funct3.
REQ-011 SHALL have port readdata, output, DATA_WIDTH, the extended load result.
REQ-012 SHALL have port stall, output, 1, the pipeline hold request.
REQ-013 SHALL have ports mem_a (output, ADDRESS_WIDTH), mem_we (output, 1), mem_writedata (output, DATA_WIDTH), mem_memcontrol (output, 3) and mem_readdata (input, DATA_WIDTH), forming the downstream data memory port with combinational read and synchronous write.

Function
REQ-014 SHALL decode address fields as offset=a[1:0], index=a[2+log2(SETS)-1:2] and tag=remaining upper bits; each line SHALL hold valid, tag and a 32-bit word.
REQ-015 SHALL implement FSM states IDLE and FILL.
REQ-016 SHALL, in IDLE with re=1 and a hit (valid and tag match), drive readdata combinationally in the same cycle with stall=0.
REQ-017 SHALL, in IDLE with re=1 and a miss, assert stall=1 combinationally and go to FILL at the next edge.
REQ-018 SHALL, in FILL, drive mem_a=a&~3, mem_memcontrol=3'b010 and mem_we=0 with stall=1; at the edge it SHALL write mem_readdata, the tag and valid=1 into the line, then return to IDLE.
REQ-019 SHALL give a load miss total latency of 3 cycles: two stall cycles followed by the hit cycle.
REQ-020 SHALL treat stores as write-through, no-write-allocate: in IDLE with we=1, the same cycle SHALL drive mem_a=a, mem_we=1, mem_writedata=writedata, mem_memcontrol=memcontrol and stall=0.
REQ-021 SHALL, on a store hit, merge the stored byte (000), half at a&~1 (001) or word (010) into the line at the same edge.
REQ-022 SHALL drive mem_we=0 outside store cycles.
REQ-023 SHALL extract loads from the line word: 000 SHALL give a sign-extended byte, 100 a zero-extended byte, 001 a sign-extended half, 101 a zero-extended half and 010 the full word.
REQ-024 SHALL, when re=1 with any other memcontrol, output readdata=32'hdeadbeef with no fill and no stall.
REQ-025 SHALL, when re=0 and we=0, output readdata=0, stall=0 and make no state change.
REQ-026 SHALL give we priority if re=1 and we=1 together, treating the access as a store.
REQ-027 SHALL rely on a, re and memcontrol being held stable by upstream while stall=1; the block SHALL ignore any change to them during FILL.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear all valid bits and set state=IDLE; stall, mem_we and readdata SHALL be 0 while rst=1.
REQ-029 SHALL, if rst=1 during FILL, abandon the fill with no line written.
REQ-030 SHALL not reset line data or tags.

Configuration
REQ-031 SHALL, when DCACHE_STATS_EN is defined, add 32-bit outputs hit_count and miss_count, both reset to 0 and wrapping at 2^32.
REQ-032 SHALL increment miss_count on each IDLE-to-FILL transition.
REQ-033 SHALL increment hit_count on each IDLE load hit, excluding the replay cycle that immediately follows FILL.
REQ-034 SHALL, without DCACHE_STATS_EN, have neither these ports nor the counter logic.

Structure
REQ-035 SHALL place the memcontrol encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum (IDLE, FILL) in the shared package dcache_pkg.
REQ-036 SHALL place load extraction and store merge in one combinational sub-module, load_store_align, reused for both paths.

Verification
REQ-037 SHALL cover: after reset, lw a=0x10000 where memory holds 0x12345678 -> stall high 2 cycles, then readdata=0x12345678; a repeat lw -> stall=0 with the same data.
REQ-038 SHALL cover: a line holding 0x80FF7F01, lb a=0x10002 -> 0xFFFFFFFF; lbu -> 0x000000FF; lh a=0x10002 -> 0xFFFF80FF; lhu a=0x10000 -> 0x00007F01.
REQ-039 SHALL cover: sb 0xAB at a=0x10001 on a hit -> memory byte written the same edge; the next lw -> 0x80FFAB01 with no stall.
REQ-040 SHALL cover: sw 0xCAFEF00D to an uncached address -> mem_we=1 for one cycle, no stall; a following lw misses and returns 0xCAFEF00D.
REQ-041 SHALL cover: lw addresses 0x10000 and 0x10020 with SETS=8 -> second evicts first; reloading 0x10000 misses again; with DCACHE_STATS_EN set, miss_count=3 and hit_count=0.
REQ-042 SHALL cover: rst asserted during FILL -> next cycle state IDLE, stall=0, and the same lw misses again.
